// File: rtl/instr_encoder.sv
// RV32I instruction word builder (ALUI, ALUR, LUI, AUIPC) with request/response
// handshakes, a small output FIFO and a saturating count of rejected requests.
module instr_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [1:0]           fmt_i,
  input  logic [2:0]           funct3_i,
  input  logic                 alt_i,
  input  logic [4:0]           rd_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [31:0]          imm_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          instr_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [1:0] FMT_ALUI  = 2'd0;
  localparam logic [1:0] FMT_ALUR  = 2'd1;
  localparam logic [1:0] FMT_LUI   = 2'd2;

  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_ALUR  = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  function automatic logic [31:0] encode_word(
    input logic [1:0]  fmt,
    input logic [2:0]  f3,
    input logic        alt,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [6:0] f7;
    f7 = alt ? 7'b0100000 : 7'b0000000;
    case (fmt)
      FMT_ALUI: begin
        // SLLI/SRLI/SRAI carry a 5-bit shamt and funct7 in the upper immediate
        if (f3[1:0] == 2'b01) encode_word = {f7, imm[4:0], rs1, f3, rd, OP_ALUI};
        else                  encode_word = {imm[11:0], rs1, f3, rd, OP_ALUI};
      end
      FMT_ALUR: encode_word = {f7, rs2, rs1, f3, rd, OP_ALUR};
      FMT_LUI:  encode_word = {imm[31:12], rd, OP_LUI};
      default:  encode_word = {imm[31:12], rd, OP_AUIPC};
    endcase
  endfunction

  function automatic logic is_malformed(
    input logic [1:0]  fmt,
    input logic [2:0]  f3,
    input logic        alt,
    input logic [31:0] imm
  );
    case (fmt)
      FMT_ALUI: begin
        if (f3[1:0] == 2'b01) is_malformed = (|imm[31:5]) | (alt & (f3 == 3'b001));
        else                  is_malformed = ~((&imm[31:11]) | ~(|imm[31:11]));
      end
      FMT_ALUR: is_malformed = alt & ~((f3 == 3'b000) | (f3 == 3'b101));
      default:  is_malformed = |imm[11:0];
    endcase
  endfunction

  logic [31:0]          mem_p1 [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_p1;
  logic [PTR_W-1:0]     rd_ptr_p1;
  logic [CNT_W-1:0]     count_p1;
  logic [CNT_W-1:0]     count_nxt;
  logic                 ready_p1;
  logic                 err_p1;
  logic [ERR_CNT_W-1:0] err_cnt_p1;

  logic [31:0] word_p0;
  logic        bad_p0;
  logic        accept_p0;
  logic        push_p0;
  logic        pop_p1;
  logic        vld_p1;

  // Stage p0: encode and classify the incoming request
  always_comb begin
    word_p0   = encode_word(fmt_i, funct3_i, alt_i, rd_i, rs1_i, rs2_i, imm_i);
    bad_p0    = is_malformed(fmt_i, funct3_i, alt_i, imm_i);
    accept_p0 = valid_i & ready_p1;
    push_p0   = accept_p0 & ~bad_p0;
    vld_p1    = (count_p1 != '0);
    pop_p1    = vld_p1 & ready_i;
    case ({push_p0, pop_p1})
      2'b10:   count_nxt = count_p1 + CNT_W'(1);
      2'b01:   count_nxt = count_p1 - CNT_W'(1);
      default: count_nxt = count_p1;
    endcase
  end

  // Stage p1: FIFO control, registered ready and error reporting
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_p1  <= '0;
      rd_ptr_p1  <= '0;
      count_p1   <= '0;
      ready_p1   <= 1'b0;
      err_p1     <= 1'b0;
      err_cnt_p1 <= '0;
    end else begin
      if (push_p0) wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
      if (pop_p1)  rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
      count_p1 <= count_nxt;
      ready_p1 <= (count_nxt < DEPTH_C);
      err_p1   <= accept_p0 & bad_p0;
      if (accept_p0 & bad_p0 & ~(&err_cnt_p1)) err_cnt_p1 <= err_cnt_p1 + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_p0) mem_p1[wr_ptr_p1] <= word_p0;
  end

  assign ready_o     = ready_p1;
  assign valid_o     = vld_p1;
  assign instr_o     = vld_p1 ? mem_p1[rd_ptr_p1] : NOP_WORD;
  assign err_o       = err_p1;
  assign err_count_o = err_cnt_p1;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised and directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 2;
  localparam int ECW   = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic           clk = 1'b0;
  logic           reset_n_i = 1'b0;
  logic           valid_i = 1'b0;
  logic           ready_o;
  logic [1:0]     fmt_i = '0;
  logic [2:0]     funct3_i = '0;
  logic           alt_i = 1'b0;
  logic [4:0]     rd_i = '0;
  logic [4:0]     rs1_i = '0;
  logic [4:0]     rs2_i = '0;
  logic [31:0]    imm_i = '0;
  logic           valid_o;
  logic           ready_i = 1'b0;
  logic [31:0]    instr_o;
  logic           err_o;
  logic [ECW-1:0] err_count_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] q[$];
  bit          m_rdy = 0;
  bit          m_err = 0;
  int          m_cnt = 0;
  bit          m_acc = 0;

  instr_encoder #(.FIFO_DEPTH(DEPTH), .ERR_CNT_W(ECW)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .fmt_i(fmt_i), .funct3_i(funct3_i), .alt_i(alt_i), .rd_i(rd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .valid_o(valid_o),
    .ready_i(ready_i), .instr_o(instr_o), .err_o(err_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  // Builds the expected word from the ISA field layout with plain arithmetic.
  function automatic void model_req(input int fmt, input int f3, input bit alt,
                                    input int rd, input int rs1, input int rs2,
                                    input logic [31:0] imm,
                                    output logic [31:0] w, output bit bad);
    logic [31:0] f7;
    int          si;
    f7 = alt ? 32'd32 : 32'd0;
    si = $signed(imm);
    case (fmt)
      0: begin
        if (f3 == 1 || f3 == 5) begin
          bad = (imm > 32'd31) || (alt && f3 == 1);
          w = (f7 << 25) | ((imm % 32) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        end else begin
          bad = (si < -2048) || (si > 2047);
          w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        end
      end
      1: begin
        bad = alt && !(f3 == 0 || f3 == 5);
        w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      end
      default: begin
        bad = (imm % 4096) != 0;
        w = (imm & 32'hFFFF_F000) | (rd << 7) | ((fmt == 2) ? 32'h37 : 32'h17);
      end
    endcase
  endfunction

  task automatic model_edge(input bit v, input int fmt, input int f3, input bit alt,
                            input int rd, input int rs1, input int rs2,
                            input logic [31:0] imm, input bit rdy, input bit rstn);
    logic [31:0] w;
    bit          bad;
    bit          acc;
    bit          pop;
    if (!rstn) begin
      q.delete();
      m_rdy = 0; m_err = 0; m_cnt = 0; m_acc = 0;
    end else begin
      acc = v && m_rdy;
      pop = (q.size() > 0) && rdy;
      m_err = 0;
      if (pop) void'(q.pop_front());
      if (acc) begin
        model_req(fmt, f3, alt, rd, rs1, rs2, imm, w, bad);
        if (bad) begin
          m_err = 1;
          if (m_cnt < (1 << ECW) - 1) m_cnt++;
        end else begin
          q.push_back(w);
        end
      end
      m_acc = acc;
      m_rdy = q.size() < DEPTH;
    end
  endtask

  task automatic drive_cycle(input bit v, input int fmt, input int f3, input bit alt,
                             input int rd, input int rs1, input int rs2,
                             input logic [31:0] imm, input bit rdy, input bit rstn);
    valid_i = v; fmt_i = 2'(fmt); funct3_i = 3'(f3); alt_i = alt;
    rd_i = 5'(rd); rs1_i = 5'(rs1); rs2_i = 5'(rs2); imm_i = imm;
    ready_i = rdy; reset_n_i = rstn;
    @(posedge clk);
    model_edge(v, fmt, f3, alt, rd, rs1, rs2, imm, rdy, rstn);
    #1;
  endtask

  task automatic idle(input bit rdy, input bit rstn);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 32'h0, rdy, rstn);
  endtask

  task automatic test_reset;
    drive_cycle(1, 0, 0, 0, 1, 0, 0, 32'd5, 1, 0);
    drive_cycle(1, 0, 0, 0, 1, 0, 0, 32'd5, 1, 0);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready_o); end
    checks++; if (instr_o !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr_o, NOP); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
    checks++; if (err_count_o !== 8'h00) begin errors++; $display("FAIL reset_errcnt got %h exp 00", err_count_o); end
    idle(1, 1);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", ready_o); end
  endtask

  task automatic test_alui_alur;
    drive_cycle(1, 0, 0, 0, 1, 0, 0, 32'd5, 0, 1);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL addi_valid got %b exp 1", valid_o); end
    checks++; if (instr_o !== 32'h0050_0093) begin errors++; $display("FAIL addi_word got %h exp 00500093", instr_o); end
    idle(1, 1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL addi_drain got %b exp 0", valid_o); end
    drive_cycle(1, 1, 0, 1, 3, 1, 2, 32'h0, 0, 1);
    checks++; if (instr_o !== 32'h4020_81B3) begin errors++; $display("FAIL sub_word got %h exp 402081b3", instr_o); end
    idle(1, 1);
  endtask

  task automatic test_shift_lui;
    drive_cycle(1, 0, 5, 1, 1, 1, 0, 32'd3, 0, 1);
    drive_cycle(1, 2, 0, 0, 5, 0, 0, 32'h1234_5000, 0, 1);
    checks++; if (instr_o !== 32'h4030_D093) begin errors++; $display("FAIL srai_word got %h exp 4030d093", instr_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", ready_o); end
    idle(1, 1);
    checks++; if (instr_o !== 32'h1234_52B7) begin errors++; $display("FAIL lui_word got %h exp 123452b7", instr_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL lui_ready got %b exp 1", ready_o); end
    idle(1, 1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL lui_drain got %b exp 0", valid_o); end
  endtask

  task automatic test_errors;
    idle(1, 0);
    idle(1, 1);
    drive_cycle(1, 0, 0, 0, 1, 1, 0, 32'h0000_0800, 1, 1);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", err_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL err_novalid got %b exp 0", valid_o); end
    checks++; if (err_count_o !== 8'd1) begin errors++; $display("FAIL err_count1 got %0d exp 1", err_count_o); end
    idle(1, 1);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_oneshot got %b exp 0", err_o); end
    for (int i = 0; i < 254; i++) drive_cycle(1, 0, 0, 0, 1, 1, 0, 32'h0000_0800, 1, 1);
    checks++; if (err_count_o !== 8'hFF) begin errors++; $display("FAIL err_count255 got %h exp ff", err_count_o); end
    drive_cycle(1, 0, 0, 0, 1, 1, 0, 32'h0000_0800, 1, 1);
    checks++; if (err_count_o !== 8'hFF) begin errors++; $display("FAIL err_saturate got %h exp ff", err_count_o); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sat_pulse got %b exp 1", err_o); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w0, w1, w2;
    bit          b;
    idle(0, 0);
    idle(0, 1);
    model_req(0, 4, 0, 7, 8, 0, 32'hFFFF_FFFF, w0, b);
    model_req(1, 5, 1, 9, 10, 11, 32'h0, w1, b);
    model_req(3, 0, 0, 12, 0, 0, 32'hABCD_E000, w2, b);
    drive_cycle(1, 0, 4, 0, 7, 8, 0, 32'hFFFF_FFFF, 0, 1);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", ready_o); end
    drive_cycle(1, 1, 5, 1, 9, 10, 11, 32'h0, 0, 1);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready2 got %b exp 0", ready_o); end
    drive_cycle(1, 3, 0, 0, 12, 0, 0, 32'hABCD_E000, 0, 1);
    checks++; if (instr_o !== w0) begin errors++; $display("FAIL bp_hold_head got %h exp %h", instr_o, w0); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_held got %b exp 0", ready_o); end
    drive_cycle(1, 3, 0, 0, 12, 0, 0, 32'hABCD_E000, 1, 1);
    checks++; if (instr_o !== w1) begin errors++; $display("FAIL bp_word1 got %h exp %h", instr_o, w1); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_again got %b exp 1", ready_o); end
    drive_cycle(1, 3, 0, 0, 12, 0, 0, 32'hABCD_E000, 1, 1);
    checks++; if (instr_o !== w2) begin errors++; $display("FAIL bp_word2 got %h exp %h", instr_o, w2); end
    idle(1, 1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", valid_o); end
  endtask

  task automatic test_mid_reset;
    drive_cycle(1, 3, 0, 0, 1, 0, 0, 32'h0000_0001, 0, 1);
    drive_cycle(1, 0, 0, 0, 2, 3, 0, 32'd100, 0, 1);
    drive_cycle(1, 2, 0, 0, 4, 0, 0, 32'h0007_0000, 0, 1);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL mr_queued got %b exp 1", valid_o); end
    idle(0, 0);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mr_valid got %b exp 0", valid_o); end
    checks++; if (instr_o !== NOP) begin errors++; $display("FAIL mr_instr got %h exp %h", instr_o, NOP); end
    checks++; if (err_count_o !== 8'h00) begin errors++; $display("FAIL mr_errcnt got %h exp 00", err_count_o); end
    idle(0, 1);
    drive_cycle(1, 0, 0, 0, 1, 0, 0, 32'd5, 0, 1);
    checks++; if (instr_o !== 32'h0050_0093) begin errors++; $display("FAIL mr_resume got %h exp 00500093", instr_o); end
    idle(1, 1);
  endtask

  task automatic test_random;
    logic [31:0] imm, r;
    logic [31:0] exp_i;
    for (int i = 0; i < 800; i++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 40));
        1: imm = {{20{r[11]}}, r[11:0]};
        2: imm = r & 32'hFFFF_F000;
        default: imm = r;
      endcase
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 7),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), imm, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 99) != 0);
      exp_i = (q.size() > 0) ? q[0] : NOP;
      checks++; if (valid_o !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, valid_o, q.size() > 0); end
      checks++; if (instr_o !== exp_i) begin errors++; $display("FAIL rnd_instr cyc %0d got %h exp %h", i, instr_o, exp_i); end
      checks++; if (ready_o !== m_rdy) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, ready_o, m_rdy); end
      checks++; if (err_o !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b exp %b", i, err_o, m_err); end
      checks++; if (err_count_o !== ECW'(m_cnt)) begin errors++; $display("FAIL rnd_errcnt cyc %0d got %0d exp %0d", i, err_count_o, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_alui_alur();
    test_shift_lui();
    test_errors();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
